// File: rtl/seq_stage_ctrl.sv
// seq_stage_ctrl: read/activate sequencer. A start request issues `len` read
// beats; each beat travels through a DEPTH-stage token pipeline that advances
// only on en=1 edges, and raises `act` when it reaches the last stage.
//
// Ports:
//   clk       in   clock, rising edge
//   reset     in   asynchronous active-low reset
//   en        in   advance/qualify; 0 stalls pipeline, counters and FSM
//   start     in   start request, sampled in IDLE only
//   len       in   beats to issue, latched on start accept (0 = ignore start)
//   done      in   synchronous abort, overrides everything but reset
//   rd        out  first pipeline stage
//   act       out  last pipeline stage
//   stage     out  token occupancy of every stage
//   busy      out  sequencer not idle
//   act_cnt   out  act beats transferred since last start accept (wraps)
//   complete  out  one-cycle pulse after a normal finish
//   stall_cnt out  busy stall edges, saturating (0 unless SEQ_STAGE_CTRL_PERF_EN)
//
// Build option: define SEQ_STAGE_CTRL_PERF_EN to include the stall counter.
module seq_stage_ctrl #(
    parameter int unsigned DEPTH = 3,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             done,
    output logic             rd,
    output logic             act,
    output logic [DEPTH-1:0] stage,
    output logic             busy,
    output logic [CNT_W-1:0] act_cnt,
    output logic             complete,
    output logic [15:0]      stall_cnt
);

    localparam int unsigned STALL_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [DEPTH-1:0]   pipe_q, pipe_d;
    logic [CNT_W-1:0]   issued_q, issued_d;
    logic [CNT_W-1:0]   len_q, len_d;
    logic [CNT_W-1:0]   act_cnt_q, act_cnt_d;
    logic               busy_q, busy_d;
    logic               complete_q, complete_d;

    logic               start_ok_c;
    logic               issue_last_c;
    logic               drain_last_c;

    // Start is only taken in IDLE, with a non-zero length, and never alongside an abort.
    assign start_ok_c   = (state_q == ST_IDLE) && start && !done && (len != '0);
    // This issuing edge emits the final beat.
    assign issue_last_c = (issued_q + CNT_W'(1)) == len_q;
    // After the next shift (with a 0 inserted) the pipeline is empty.
    assign drain_last_c = (pipe_q[DEPTH-2:0] == '0);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        if (done) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  if (start_ok_c) state_d = ST_ISSUE;
                ST_ISSUE: if (en && issue_last_c) state_d = ST_DRAIN;
                ST_DRAIN: if (en && drain_last_c) state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // Datapath / output next values.
    always_comb begin
        pipe_d     = pipe_q;
        issued_d   = issued_q;
        len_d      = len_q;
        act_cnt_d  = act_cnt_q;
        complete_d = 1'b0;
        busy_d     = (state_d != ST_IDLE);

        // An act beat presented on the abort edge still transfers, so count it first.
        if (pipe_q[DEPTH-1] && en) begin
            act_cnt_d = act_cnt_q + CNT_W'(1);
        end

        if (done) begin
            pipe_d   = '0;
            issued_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_ok_c) begin
                        len_d     = len;
                        issued_d  = '0;
                        act_cnt_d = '0;
                    end
                end
                ST_ISSUE: begin
                    if (en) begin
                        pipe_d   = {pipe_q[DEPTH-2:0], 1'b1};
                        issued_d = issued_q + CNT_W'(1);
                    end
                end
                ST_DRAIN: begin
                    if (en) begin
                        pipe_d     = {pipe_q[DEPTH-2:0], 1'b0};
                        complete_d = drain_last_c;
                    end
                end
                default: ;
            endcase
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pipe_q     <= '0;
            issued_q   <= '0;
            len_q      <= '0;
            act_cnt_q  <= '0;
            busy_q     <= 1'b0;
            complete_q <= 1'b0;
        end else begin
            pipe_q     <= pipe_d;
            issued_q   <= issued_d;
            len_q      <= len_d;
            act_cnt_q  <= act_cnt_d;
            busy_q     <= busy_d;
            complete_q <= complete_d;
        end
    end

    assign rd       = pipe_q[0];
    assign act      = pipe_q[DEPTH-1];
    assign stage    = pipe_q;
    assign busy     = busy_q;
    assign act_cnt  = act_cnt_q;
    assign complete = complete_q;

`ifdef SEQ_STAGE_CTRL_PERF_EN
    logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;

    // Saturating count of stalled edges while busy; cleared by a new start.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (start_ok_c) begin
            stall_cnt_d = '0;
        end else if ((state_q != ST_IDLE) && !en && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + STALL_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_stage_ctrl.sv
// Bench for seq_stage_ctrl: two instances (DEPTH=3/CNT_W=8 and DEPTH=16/CNT_W=4)
// checked every cycle against a beat-count model, plus literal expectations.
module tb_seq_stage_ctrl;

    localparam int unsigned D0 = 3;
    localparam int unsigned W0 = 8;
    localparam int unsigned D1 = 16;
    localparam int unsigned W1 = 4;

`ifdef SEQ_STAGE_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic          clk   = 1'b0;
    logic          reset = 1'b1;
    logic          en    = 1'b1;
    logic          start = 1'b0;
    logic          done  = 1'b0;
    logic [W0-1:0] len_a = '0;
    logic [W1-1:0] len_b = '0;

    logic          rd_a, act_a, busy_a, complete_a;
    logic [D0-1:0] stage_a;
    logic [W0-1:0] act_cnt_a;
    logic [15:0]   stall_a;

    logic          rd_b, act_b, busy_b, complete_b;
    logic [D1-1:0] stage_b;
    logic [W1-1:0] act_cnt_b;
    logic [15:0]   stall_b;

    seq_stage_ctrl #(.DEPTH(D0), .CNT_W(W0)) u_a (
        .clk(clk), .reset(reset), .en(en), .start(start), .len(len_a), .done(done),
        .rd(rd_a), .act(act_a), .stage(stage_a), .busy(busy_a), .act_cnt(act_cnt_a),
        .complete(complete_a), .stall_cnt(stall_a)
    );

    seq_stage_ctrl #(.DEPTH(D1), .CNT_W(W1)) u_b (
        .clk(clk), .reset(reset), .en(en), .start(start), .len(len_b), .done(done),
        .rd(rd_b), .act(act_b), .stage(stage_b), .busy(busy_b), .act_cnt(act_cnt_b),
        .complete(complete_b), .stall_cnt(stall_b)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input longint got, input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
    endtask

    // Model: k counts en edges since start accept. Beat j (1..n) occupies stage i
    // when k-i == j, so stage i is full while 1 <= k-i <= n; the run ends when k = n+depth.
    typedef struct {
        bit busy;
        int n;
        int k;
        int acnt;
        int stall;
        bit cmpl;
    } model_t;

    model_t ma, mb;

    function automatic model_t m_reset();
        model_t r;
        r.busy = 1'b0; r.n = 0; r.k = 0; r.acnt = 0; r.stall = 0; r.cmpl = 1'b0;
        return r;
    endfunction

    function automatic bit m_stage(model_t m, int i);
        return m.busy && (m.k - i >= 1) && (m.k - i <= m.n);
    endfunction

    function automatic model_t m_step(model_t m, int depth, int cw, bit e, bit s, bit d, int l);
        model_t r = m;
        if (m.busy && !e && m.stall < 65535) r.stall = m.stall + 1;
        if (m_stage(m, depth - 1) && e) r.acnt = (m.acnt + 1) % (1 << cw);
        r.cmpl = 1'b0;
        if (d) begin
            r.busy = 1'b0;
        end else if (!m.busy) begin
            if (s && l != 0) begin
                r.busy = 1'b1; r.n = l; r.k = 0; r.acnt = 0; r.stall = 0;
            end
        end else if (e) begin
            r.k = m.k + 1;
            if (r.k == m.n + depth) begin
                r.busy = 1'b0;
                r.cmpl = 1'b1;
            end
        end
        return r;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            ma <= m_reset();
            mb <= m_reset();
        end else begin
            ma <= m_step(ma, D0, W0, en, start, done, int'(len_a));
            mb <= m_step(mb, D1, W1, en, start, done, int'(len_b));
        end
    end

    task automatic cmp_dut(input string tag, input model_t m, input int depth,
                           input longint rd_v, input longint act_v, input longint stage_v,
                           input longint busy_v, input longint acnt_v, input longint cmpl_v,
                           input longint stall_v);
        longint s = 0;
        for (int i = 0; i < depth; i++) if (m_stage(m, i)) s |= (longint'(1) << i);
        chk({tag, ".rd"},       rd_v,    longint'(m_stage(m, 0)));
        chk({tag, ".act"},      act_v,   longint'(m_stage(m, depth - 1)));
        chk({tag, ".stage"},    stage_v, s);
        chk({tag, ".busy"},     busy_v,  longint'(m.busy));
        chk({tag, ".act_cnt"},  acnt_v,  longint'(m.acnt));
        chk({tag, ".complete"}, cmpl_v,  longint'(m.cmpl));
        chk({tag, ".stall"},    stall_v, PERF ? longint'(m.stall) : 0);
    endtask

    // Every-cycle comparison against the model, mid-cycle.
    always @(negedge clk) begin
        if (reset) begin
            cmp_dut("a", ma, D0, rd_a, act_a, stage_a, busy_a, act_cnt_a, complete_a, stall_a);
            cmp_dut("b", mb, D1, rd_b, act_b, stage_b, busy_b, act_cnt_b, complete_b, stall_b);
        end
    end

    logic [63:0] rda_h, acta_h, busya_h, cmpa_h, actb_h, cmpb_h;

    // Drive one input vector per cycle (cycle 0 = the current one) and record output history.
    task automatic run_seq(input logic [63:0] en_m, input logic [63:0] start_m,
                           input logic [63:0] done_m, input int la, input int lb, input int ncyc);
        rda_h = '0; acta_h = '0; busya_h = '0; cmpa_h = '0; actb_h = '0; cmpb_h = '0;
        for (int c = 0; c < ncyc; c++) begin
            rda_h[c]   = rd_a;
            acta_h[c]  = act_a;
            busya_h[c] = busy_a;
            cmpa_h[c]  = complete_a;
            actb_h[c]  = act_b;
            cmpb_h[c]  = complete_b;
            en    = en_m[c];
            start = start_m[c];
            done  = done_m[c];
            len_a = W0'(la);
            len_b = W1'(lb);
            @(negedge clk);
        end
        en = 1'b1; start = 1'b0; done = 1'b0; len_a = '0; len_b = '0;
    endtask

    initial begin
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst.busy", busy_a, 0);
        chk("rst.act_cnt", act_cnt_a, 0);
        @(negedge clk);
        reset = 1'b1;

        // Reset in the middle of an issue burst.
        run_seq('1, 64'h1, '0, 5, 0, 4);
        chk("rmid.busy_before", busy_a, 1);
        chk("rmid.rd_before", rd_a, 1);
        #2 reset = 1'b0;
        #1;
        chk("rmid.rd", rd_a, 0);
        chk("rmid.act", act_a, 0);
        chk("rmid.stage", stage_a, 0);
        chk("rmid.busy", busy_a, 0);
        chk("rmid.act_cnt", act_cnt_a, 0);
        chk("rmid.stall", stall_a, 0);
        @(negedge clk);
        reset = 1'b1;
        run_seq('1, 64'h1, '0, 2, 0, 8);
        chk("rpost.complete", cmpa_h, 64'h40);
        chk("rpost.act_cnt", act_cnt_a, 2);

        // Continuous en, len=4.
        run_seq('1, 64'h1, '0, 4, 0, 12);
        chk("cont.rd", rda_h, 64'h03C);
        chk("cont.act", acta_h, 64'h0F0);
        chk("cont.busy", busya_h, 64'h0FE);
        chk("cont.complete", cmpa_h, 64'h100);
        chk("cont.act_cnt", act_cnt_a, 4);

        // Same with en low in cycles 3-4.
        run_seq(~64'h18, 64'h1, '0, 4, 0, 12);
        chk("stall.rd", rda_h, 64'h0FC);
        chk("stall.act", acta_h, 64'h3C0);
        chk("stall.complete", cmpa_h, 64'h400);
        chk("stall.act_cnt", act_cnt_a, 4);
        chk("stall.stall_cnt", stall_a, PERF ? 2 : 0);

        // Abort at cycle 5 of a len=6 run.
        run_seq('1, 64'h1, 64'h20, 6, 0, 10);
        chk("abort.rd", rda_h, 64'h03C);
        chk("abort.act", acta_h, 64'h030);
        chk("abort.busy", busya_h, 64'h03E);
        chk("abort.complete", cmpa_h, 64'h0);
        chk("abort.act_cnt", act_cnt_a, 2);

        // len=0 start, and start together with done, are both ignored.
        run_seq('1, 64'h1, '0, 0, 0, 4);
        chk("len0.busy", busya_h, 0);
        run_seq('1, 64'h1, 64'h1, 5, 0, 4);
        chk("startdone.busy", busya_h, 0);
        chk("idle.act_cnt_held", act_cnt_a, 2);

        // Second start while busy is ignored.
        run_seq('1, 64'h9, '0, 3, 0, 10);
        chk("rebusy.rd", rda_h, 64'h01C);
        chk("rebusy.complete", cmpa_h, 64'h080);
        chk("rebusy.act_cnt", act_cnt_a, 3);

        // Deep pipeline: DEPTH=16, CNT_W=4, len=15.
        run_seq('1, 64'h1, '0, 0, 15, 40);
        chk("deep.act", actb_h, 64'hFFFE_0000);
        chk("deep.complete", cmpb_h, 64'h1_0000_0000);
        chk("deep.act_cnt", act_cnt_b, 15);
        chk("deep.a_idle", busya_h, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/seq_stage_ctrl.md
# seq_stage_ctrl

Parametrised read/activate sequencer for the datapath controller. On a start request it issues a programmed number of read beats, propagates each beat through a DEPTH-stage enable-gated token pipeline, and raises `act` when the beat reaches the last stage. It supports external stall (`en`), synchronous abort (`done`) and completion signalling. It replaces fixed three-stage rd/act controllers in front of the compute array.

## Interface
- DEPTH, 3: pipeline stages from rd to act; legal range 2..16.
- CNT_W, 8: width of the beat-length and beat counters.
---
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-low; clears all state.
- en  in  1  advance/qualify; 0 = stall (pipeline and counters hold).
- start  in  1  request; sampled only in IDLE.
- len  in  CNT_W  beats to issue; latched on start accept; 0 = start ignored.
- done  in  1  synchronous abort; priority over everything except reset.
- rd  out  1  registered, = pipe[0].
- act  out  1  registered, = pipe[DEPTH-1].
- stage  out  DEPTH  token occupancy of each pipeline stage.
- busy  out  1  state != IDLE.
- act_cnt  out  CNT_W  act beats transferred since last start accept.
- complete  out  1  one-cycle pulse on normal (non-aborted) finish.
- stall_cnt  out  16  stall cycles (only with SEQ_STAGE_CTRL_PERF_EN).

## Operation
- Reset values: rd=0, act=0, stage=0, busy=0, act_cnt=0, complete=0, stall_cnt=0; state IDLE; issued=0.
- Beat contract: a rd/act beat transfers on a cycle where the signal is 1 and en=1; with en=0 the signal holds and no transfer occurs.
- FSM states IDLE, ISSUE, DRAIN.
- IDLE: start=1 and len!=0 -> latch len, clear issued and act_cnt, go ISSUE. start with len=0: no action.
- ISSUE: on each edge with en=1, pipe shifts (pipe[i]<=pipe[i-1]); pipe[0]<=1 and issued++ while issued<len. The edge that makes issued==len moves to DRAIN.
- DRAIN: pipe[0]<=0 on each en=1 edge. The edge that leaves pipe all-zero returns to IDLE and asserts complete for the following cycle.
- act_cnt increments on each edge with act=1 and en=1. It wraps modulo 2^CNT_W and is held in IDLE.
- done=1 at an edge, in any state: pipe<=0, issued<=0, state<=IDLE, complete stays 0, act_cnt retains its value. done in IDLE is a no-op. done with start in the same cycle: start is ignored.
- Stall (en=0) in ISSUE or DRAIN freezes pipe, issued and state. start is ignored while busy.

## Timing
- Start sampled at edge E0 -> busy=1 and state ISSUE after E0.
- First rd after E1 (with en=1), i.e. 2 cycles after start.
- act for a beat appears DEPTH-1 en-cycles after its rd.
- Continuous en, len=N: rd high N cycles; act high N cycles beginning DEPTH-1 cycles after the first rd. complete pulses in the cycle after the last act cycle, with busy=0 in the same cycle.
- Abort latency: rd/act/busy are 0 in the cycle after the done edge.

## Configuration
- SEQ_STAGE_CTRL_PERF_EN defined: stall_cnt counts edges with busy=1 and en=0. It saturates at 0xFFFF, is cleared on start accept, and holds through abort.
- SEQ_STAGE_CTRL_PERF_EN undefined: stall_cnt is tied to 0 and no counter logic is synthesised. All other behaviour is identical.

## Test plan
- Reset mid-ISSUE (DEPTH=3, len=5, reset low at cycle 4) -> all outputs 0 immediately, asynchronously; after release start is accepted normally.
- DEPTH=3, len=4, en=1 continuous, start at cycle 0 -> rd high cycles 2-5, act high cycles 4-7, complete at cycle 8, act_cnt=4.
- Same stimulus with en=0 at cycles 3-4 -> rd high cycles 2-7 (no transfer at 3-4), act_cnt=4 at end, complete delayed 2 cycles, stall_cnt=2 with PERF_EN.
- Abort: len=6, done=1 at cycle 5 -> rd=act=busy=0 from cycle 6, complete never pulses, act_cnt=2.
- len=0 start in IDLE -> busy stays 0; start while busy -> ignored, beat count unchanged.
- DEPTH=16, CNT_W=4, len=15 -> act high 15 cycles starting 15 cycles after first rd; act_cnt=15, complete pulses once.
